// File: rtl/demux1to2_stream_pkg.sv
// demux1to2_stream_pkg: shared FIFO depth and channel index constants
package demux1to2_stream_pkg;
  localparam int FIFO_DEPTH = 2;
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;
endpackage

// File: rtl/demux1to2_stream_fifo2.sv
// stream_fifo2: 2-entry in-order FIFO with push/pop, full/empty and registered head
module stream_fifo2
  import demux1to2_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic             wr_q, wr_d, rd_q, rd_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_push, do_pop;
  assign full  = cnt_q == 2'(FIFO_DEPTH);
  assign empty = cnt_q == 2'd0;
  assign head  = mem_q[rd_q];
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = (do_push && wr_q == 1'(i)) ? din : mem_q[i];
    wr_d  = wr_q ^ do_push;
    rd_d  = rd_q ^ do_pop;
    cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/demux1to2_stream.sv
// demux1to2_stream: registered 1-to-2 stream demux with explicit or round-robin routing
module demux1to2_stream
  import demux1to2_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic             mode,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  logic             tgt, accept, push0, push1;
  logic             full0, full1, empty0, empty1;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  always_comb begin
    tgt      = mode ? rr_q : in_sel;
    in_ready = (tgt == CH1) ? !full1 : !full0;
    accept   = in_valid && in_ready;
    push0    = accept && tgt == CH0;
    push1    = accept && tgt == CH1;
    rr_d     = rr_q ^ (accept && mode);
    cnt0_d   = cnt0_q + CNT_W'(push0);
    cnt1_d   = cnt1_q + CNT_W'(push1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q   <= 1'b0;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      rr_q   <= rr_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;
  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  stream_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .push(push0), .pop(out0_ready), .din(in_data),
    .full(full0), .empty(empty0), .head(out0_data)
  );
  stream_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .push(push1), .pop(out1_ready), .din(in_data),
    .full(full1), .empty(empty1), .head(out1_data)
  );
endmodule

// File: tb/tb_demux1to2_stream.sv
// tb_demux1to2_stream: directed and random checks of demux1to2_stream against a queue model
module tb_demux1to2_stream;
  logic       clk, rst_n, in_valid, in_sel, mode, out0_ready, out1_ready;
  logic [7:0] in_data;
  logic       in_ready, out0_valid, out1_valid, in_ready_w, out0_valid_w, out1_valid_w;
  logic [7:0] out0_data, out1_data, cnt0, cnt1, out0_data_w, out1_data_w;
  logic [1:0] cnt0_w, cnt1_w;
  logic [7:0] q0[$], q1[$];
  int         c0, c1, n_vec, n_err;
  bit         rr, stall;
  demux1to2_stream #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sel(in_sel),
    .mode(mode), .in_ready(in_ready), .out0_data(out0_data), .out0_valid(out0_valid),
    .out0_ready(out0_ready), .out1_data(out1_data), .out1_valid(out1_valid),
    .out1_ready(out1_ready), .cnt0(cnt0), .cnt1(cnt1)
  );
  demux1to2_stream #(.WIDTH(8), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sel(in_sel),
    .mode(mode), .in_ready(in_ready_w), .out0_data(out0_data_w), .out0_valid(out0_valid_w),
    .out0_ready(out0_ready), .out1_data(out1_data_w), .out1_valid(out1_valid_w),
    .out1_ready(out1_ready), .cnt0(cnt0_w), .cnt1(cnt1_w)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic apply(input logic rst, input logic v, input logic sel, input logic md,
                       input logic r0, input logic r1, input logic [7:0] d);
    bit t, rdy, acc;
    rst_n = rst; in_valid = v; in_sel = sel; mode = md; out0_ready = r0; out1_ready = r1; in_data = d;
    #1;
    t   = md ? rr : sel;
    rdy = (t ? q1.size() : q0.size()) < 2;
    check("in_ready", 32'(in_ready), 32'(rdy));
    check("out0_valid", 32'(out0_valid), 32'(q0.size() > 0));
    check("out1_valid", 32'(out1_valid), 32'(q1.size() > 0));
    if (q0.size() > 0) check("out0_data", 32'(out0_data), 32'(q0[0]));
    if (q1.size() > 0) check("out1_data", 32'(out1_data), 32'(q1[0]));
    check("cnt0", 32'(cnt0), 32'(c0 % 256));
    check("cnt1", 32'(cnt1), 32'(c1 % 256));
    check("cnt0_w2", 32'(cnt0_w), 32'(c0 % 4));
    check("cnt1_w2", 32'(cnt1_w), 32'(c1 % 4));
    check("in_ready_w2", 32'(in_ready_w), 32'(rdy));
    acc   = rst && v && rdy;
    stall = rst && v && !rdy;
    if (!rst) begin
      q0.delete(); q1.delete(); c0 = 0; c1 = 0; rr = 0;
    end else begin
      if (r0 && q0.size() > 0) void'(q0.pop_front());
      if (r1 && q1.size() > 0) void'(q1.pop_front());
      if (acc && !t) begin q0.push_back(d); c0++; end
      if (acc && t) begin q1.push_back(d); c1++; end
      if (acc && md) rr = !rr;
    end
    @(negedge clk);
  endtask
  initial begin
    logic [7:0] rd;
    logic       rs;
    n_vec = 0; n_err = 0; c0 = 0; c1 = 0; rr = 0; stall = 0;
    rst_n = 0; in_valid = 1; in_sel = 0; mode = 0; out0_ready = 1; out1_ready = 1; in_data = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    apply(1, 0, 0, 0, 1, 1, 8'h00);
    apply(1, 1, 0, 0, 1, 1, 8'hA5);
    apply(1, 0, 0, 0, 1, 1, 8'h00);
    apply(1, 1, 1, 0, 1, 0, 8'h11);
    apply(1, 1, 1, 0, 1, 0, 8'h22);
    apply(1, 1, 1, 0, 1, 0, 8'h55);
    apply(1, 0, 0, 0, 1, 0, 8'h00);
    repeat (3) apply(1, 0, 0, 0, 1, 1, 8'h00);
    apply(1, 1, 0, 1, 1, 1, 8'h01);
    apply(1, 1, 0, 1, 1, 1, 8'h02);
    apply(1, 1, 0, 1, 1, 1, 8'h03);
    apply(1, 1, 0, 1, 1, 1, 8'h04);
    repeat (2) apply(1, 0, 0, 0, 1, 1, 8'h00);
    apply(1, 1, 0, 0, 0, 1, 8'h33);
    apply(1, 1, 0, 0, 1, 1, 8'h44);
    apply(1, 0, 0, 0, 0, 1, 8'h00);
    check("head_after_pushpop", 32'(out0_data), 32'h44);
    apply(1, 1, 0, 0, 1, 1, 8'h00);
    apply(1, 1, 0, 0, 0, 1, 8'h66);
    apply(1, 1, 0, 0, 0, 1, 8'h77);
    apply(1, 1, 1, 1, 0, 1, 8'h88);
    apply(0, 1, 0, 0, 0, 0, 8'h99);
    apply(1, 0, 0, 0, 0, 0, 8'h00);
    apply(1, 1, 1, 1, 1, 1, 8'hC0);
    apply(1, 0, 0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 5; i++) apply(1, 1, 1, 0, 1, 1, 8'(8'hD0 + i));
    apply(1, 0, 0, 0, 1, 1, 8'h00);
    check("cnt1_wrap_w2", 32'(cnt1_w), 32'd1);
    for (int i = 0; i < 400; i++) begin
      rd = stall ? in_data : 8'($urandom);
      rs = stall ? in_sel : 1'($urandom);
      apply(($urandom_range(0, 49) != 0), 1'($urandom), rs, 1'($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0), rd);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
